vga_pixel_unpacker: RTL and testbench
=====================================

Name: vga_pixel_unpacker

Overview:
- Successor to the fixed 32-bit/8-bit VGA byte selector.
- Buffers frame-buffer words in a small FIFO and unpacks each word into LANES pixels of PIX_W bits.
- Emits one registered pixel per pixel strobe during active video.
- Sits between the frame-buffer read port (valid/ready) and the VGA timing generator and DAC.

Parameters:
- WORD_W, 32, memory word width; must be an integer multiple of PIX_W.
- PIX_W, 8, pixel width. LANES = WORD_W/PIX_W, must be ≥2.
- FIFO_DEPTH, 4, word FIFO depth; power of 2, ≥2.
- BLANK_PIX, 0, value driven on underrun and outside active video.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- word_data  in  WORD_W  frame-buffer word.
- word_valid  in  1  word_data valid.
- word_ready  out  1  FIFO can accept a word.
- frame_start  in  1  one-cycle pulse at frame start; flushes buffered data.
- pix_en  in  1  pixel strobe from the timing generator.
- de  in  1  display enable (active video).
- vga_data  out  PIX_W  registered pixel.
- pix_valid  out  1  pulses when vga_data updates.
- underrun  out  1  sticky underrun flag.
- underrun_clr  in  1  clears underrun.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words held in the FIFO; excludes the current word.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO empty; cur_valid=0; lane_idx=0.
  - vga_data=BLANK_PIX; pix_valid=0; underrun=0; fifo_level=0.
  - word_ready=0 during reset; it rises in the cycle after reset deasserts, provided the FIFO is not full.
- Priority order: reset > frame_start > normal operation.
- Push:
  - word_ready = !full && !frame_start.
  - A word is accepted when word_valid && word_ready.
  - When full, word_ready=0 even if a pop occurs the same cycle; there is no pass-through.
- Current-word register:
  - Loads from the FIFO head (pop) when the FIFO is not empty and either:
    - cur_valid=0, in any cycle (prefetch, independent of pix_en); or
    - the last lane (lane_idx=LANES-1) is consumed this cycle.
  - After a load, lane_idx=0 and cur_valid=1.
  - If the last lane is consumed while the FIFO is empty, cur_valid=0.
- Pixel output, one-cycle latency after pix_en:
  - pix_en=1, de=1, cur_valid=1: vga_data <= cur_word[lane_idx*PIX_W +: PIX_W]. Lane 0 is the LSBs. lane_idx increments and wraps after LANES-1.
  - pix_en=1, de=1, cur_valid=0: vga_data <= BLANK_PIX, underrun <= 1, nothing consumed.
  - pix_en=1, de=0: vga_data <= BLANK_PIX, nothing consumed.
  - pix_valid <= pix_en in all three cases.
  - pix_en=0: vga_data holds; pix_valid <= 0.
- Simultaneous push and pop: fifo_level is unchanged; pointers wrap modulo FIFO_DEPTH.
- frame_start:
  - Synchronously clears the FIFO pointers and level, cur_valid and lane_idx.
  - A word presented that cycle is not accepted.
  - vga_data and underrun are unchanged.
  - A pix_en arriving the same cycle is treated as pix_en with cur_valid=0 and de as given.
- underrun_clr: clears underrun next cycle. If a new underrun occurs the same cycle, set wins.
- Reset mid-operation discards all buffered words and partial lanes.

Optional Feature:
- Macro: VGA_LANE_SWAP_EN.
- Defined: lanes are consumed MSB-first. Lane k maps to cur_word[(LANES-1-k)*PIX_W +: PIX_W], for big-endian frame buffers.
- Undefined: LSB-first as above.
- All other timing is identical in both builds.

Test Plan:
- Reset, then push 0x44332211 and 0x88776655, hold de=1, pix_en every cycle → vga_data sequence 11,22,33,44,55,66,77,88 with no gap between words, pix_valid high each cycle, underrun=0.
- Push 5 words with FIFO_DEPTH=4, no pixel strobes → fifo_level reaches 4 after 5 accepted words (one in the current register), word_ready=0, the 6th word is held off until pixels drain.
- Empty FIFO, de=1, pix_en=1 → vga_data=BLANK_PIX (0x00), underrun=1. Assert underrun_clr → underrun=0 next cycle.
- de=0 with pix_en pulses and a word loaded → vga_data=0x00, lane_idx unchanged; with de=1 the first pixel is 0x11.
- Mid-word (after 0x11,0x22), pulse frame_start with word_valid=1 → that word is not accepted, fifo_level=0, and the next pix_en with de=1 yields BLANK_PIX.
- With VGA_LANE_SWAP_EN defined, push 0x44332211 → output sequence 44,33,22,11.

Source files
------------

// File: rtl/vga_pixel_unpacker.sv
// vga_pixel_unpacker: buffers frame-buffer words in a small FIFO and unpacks
// each word into LANES pixels of PIX_W bits, one registered pixel per strobe.
// Optional build macro: VGA_LANE_SWAP_EN (consume lanes MSB-first).
module vga_pixel_unpacker #(
  parameter int unsigned       WORD_W     = 32,
  parameter int unsigned       PIX_W      = 8,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter logic [PIX_W-1:0]  BLANK_PIX  = '0
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic [WORD_W-1:0]               i_word_data,
  input  logic                            i_word_valid,
  output logic                            o_word_ready,
  input  logic                            i_frame_start,
  input  logic                            i_pix_en,
  input  logic                            i_de,
  output logic [PIX_W-1:0]                o_vga_data,
  output logic                            o_pix_valid,
  output logic                            o_underrun,
  input  logic                            i_underrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level
);

  localparam int unsigned LANES = WORD_W / PIX_W;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = $clog2(LANES);

  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_level;
  logic [WORD_W-1:0] r_cur_word;
  logic              r_cur_valid;
  logic [LW-1:0]     r_lane_idx;
  logic [PIX_W-1:0]  r_vga_data;
  logic              r_pix_valid;
  logic              r_underrun;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_consume;
  logic              w_last;
  logic              w_pop;
  logic [PIX_W-1:0]  w_lane_pix;

  assign w_full    = (r_level == (AW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_level == '0);
  // Held low while reset is asserted so nothing is accepted into a FIFO being cleared.
  assign o_word_ready = i_rst_n && !w_full && !i_frame_start;
  assign w_push    = i_word_valid && o_word_ready;
  // frame_start makes the current word look invalid for this cycle.
  assign w_consume = i_pix_en && i_de && r_cur_valid && !i_frame_start;
  assign w_last    = w_consume && (r_lane_idx == LW'(LANES - 1));
  assign w_pop     = !w_empty && !i_frame_start && (!r_cur_valid || w_last);

  assign o_vga_data   = r_vga_data;
  assign o_pix_valid  = r_pix_valid;
  assign o_underrun   = r_underrun;
  assign o_fifo_level = r_level;

  // Select the pixel for the current lane; lane order depends on build option.
  always_comb begin
    w_lane_pix = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (r_lane_idx == LW'(k)) begin
`ifdef VGA_LANE_SWAP_EN
        w_lane_pix = r_cur_word[(LANES-1-k)*PIX_W +: PIX_W];
`else
        w_lane_pix = r_cur_word[k*PIX_W +: PIX_W];
`endif
      end
    end
  end

  // FIFO storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_word_data;
    end
  end

  // FIFO pointers and level.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_frame_start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_level <= r_level + (AW+1)'(1);
      else if (w_pop && !w_push) r_level <= r_level - (AW+1)'(1);
    end
  end

  // Current-word register and lane index.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_frame_start) begin
      r_cur_word  <= '0;
      r_cur_valid <= 1'b0;
      r_lane_idx  <= '0;
    end else if (w_pop) begin
      r_cur_word  <= r_mem[r_rd_ptr];
      r_cur_valid <= 1'b1;
      r_lane_idx  <= '0;
    end else if (w_last) begin
      r_cur_valid <= 1'b0;
      r_lane_idx  <= '0;
    end else if (w_consume) begin
      r_lane_idx  <= r_lane_idx + LW'(1);
    end
  end

  // Registered pixel output, pixel strobe echo and sticky underrun.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vga_data  <= BLANK_PIX;
      r_pix_valid <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_pix_valid <= i_pix_en;
      if (i_pix_en) begin
        r_vga_data <= w_consume ? w_lane_pix : BLANK_PIX;
      end
      if (i_pix_en && i_de && !w_consume) begin
        r_underrun <= 1'b1;
      end else if (i_underrun_clr) begin
        r_underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_unpacker.sv
// Directed bench for vga_pixel_unpacker (default parameters).
// Expected pixel order follows VGA_LANE_SWAP_EN when it is defined.
module tb_vga_pixel_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        frame_start;
  logic        pix_en;
  logic        de;
  logic [7:0]  vga_data;
  logic        pix_valid;
  logic        underrun;
  logic        underrun_clr;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  vga_pixel_unpacker #(.WORD_W(32), .PIX_W(8), .FIFO_DEPTH(4), .BLANK_PIX(8'h00)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_word_data(word_data), .i_word_valid(word_valid),
    .o_word_ready(word_ready), .i_frame_start(frame_start), .i_pix_en(pix_en), .i_de(de),
    .o_vga_data(vga_data), .o_pix_valid(pix_valid), .o_underrun(underrun),
    .i_underrun_clr(underrun_clr), .o_fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected byte for pixel k of a word, from the known frame-buffer byte order.
  function automatic logic [7:0] px(input logic [31:0] w, input int k);
`ifdef VGA_LANE_SWAP_EN
    return w[(3-k)*8 +: 8];
`else
    return w[k*8 +: 8];
`endif
  endfunction

  initial begin
    logic [31:0] w0, w1;
    rst_n = 1'b0; word_data = '0; word_valid = 1'b0; frame_start = 1'b0;
    pix_en = 1'b0; de = 1'b0; underrun_clr = 1'b0;

    // Reset state
    step(); step();
    check("rst_vga", vga_data, 8'h00);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_underrun", underrun, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", word_ready, 0);
    rst_n = 1'b1; #1;
    check("ready_after_rst", word_ready, 1);

    // Two words streamed back to back
    w0 = 32'h44332211; w1 = 32'h88776655;
    word_valid = 1'b1; word_data = w0; step();
    check("lvl_one", fifo_level, 1);
    word_data = w1; step();
    check("lvl_push_pop", fifo_level, 1);
    word_valid = 1'b0; pix_en = 1'b1; de = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("w0_pix%0d", k), vga_data, px(w0, k));
      check($sformatf("w0_pv%0d", k), pix_valid, 1);
    end
    check("lvl_after_w0", fifo_level, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("w1_pix%0d", k), vga_data, px(w1, k));
      check($sformatf("w1_pv%0d", k), pix_valid, 1);
    end
    check("no_underrun", underrun, 0);
    pix_en = 1'b0; step();
    check("pv_drop", pix_valid, 0);
    check("vga_hold", vga_data, px(w1, 3));

    // Fill: five words accepted, FIFO full, sixth held off
    word_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      word_data = 32'h13121110 + 32'h04040404 * i;
      step();
    end
    check("lvl_full", fifo_level, 4);
    word_data = 32'h27262524; #1;
    check("ready_full", word_ready, 0);
    step();
    check("lvl_full_hold", fifo_level, 4);
    pix_en = 1'b1; de = 1'b1;
    step(); step(); step();
    check("ready_still_full", word_ready, 0);
    step();
    check("drain_pix", vga_data, px(32'h13121110, 3));
    check("lvl_drain", fifo_level, 3);
    check("ready_reopen", word_ready, 1);
    pix_en = 1'b0; step();
    check("lvl_sixth", fifo_level, 4);
    word_valid = 1'b0;

    // Flush, then underrun and its clear
    frame_start = 1'b1; step();
    frame_start = 1'b0;
    check("flush_lvl", fifo_level, 0);
    check("flush_vga_kept", vga_data, px(32'h13121110, 3));
    pix_en = 1'b1; de = 1'b1; step();
    check("ur_vga", vga_data, 8'h00);
    check("ur_flag", underrun, 1);
    check("ur_pv", pix_valid, 1);
    pix_en = 1'b0; step();
    check("ur_sticky", underrun, 1);
    underrun_clr = 1'b1; step();
    underrun_clr = 1'b0;
    check("ur_clr", underrun, 0);

    // Blanking with a word loaded leaves the lane untouched
    word_valid = 1'b1; word_data = w0; step();
    word_valid = 1'b0; step();
    check("lvl_loaded", fifo_level, 0);
    pix_en = 1'b1; de = 1'b0; step();
    check("blank0", vga_data, 8'h00);
    check("blank_pv", pix_valid, 1);
    step();
    check("blank1", vga_data, 8'h00);
    check("blank_no_ur", underrun, 0);
    de = 1'b1; step();
    check("de_first", vga_data, px(w0, 0));
    step();
    check("de_second", vga_data, px(w0, 1));

    // Mid-word frame_start rejects the offered word
    pix_en = 1'b0; frame_start = 1'b1; word_valid = 1'b1; word_data = 32'h99999999; #1;
    check("fs_ready", word_ready, 0);
    step();
    frame_start = 1'b0; word_valid = 1'b0;
    check("fs_lvl", fifo_level, 0);
    check("fs_vga_kept", vga_data, px(w0, 1));
    pix_en = 1'b1; de = 1'b1; step();
    check("fs_blank", vga_data, 8'h00);
    check("fs_ur", underrun, 1);
    pix_en = 1'b0; step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
